// File: rtl/dma_copy_engine.sv
// dma_copy_engine: single-channel word copy engine with a two-register slave port.
//
// Ports
//   clk, rst_n                   clock, asynchronous active-low reset
//   s_req/s_we/s_addr/s_wdata    slave request (already qualified by the bus decode)
//   s_gnt/s_rvalid/s_rdata       slave grant (always 1), read response one cycle later
//   m_req/m_we/m_addr/m_wdata/m_be  master request, held until m_gnt
//   m_gnt/m_rvalid/m_rdata       master grant and read response
//   irq                          done interrupt level
//
// Registers (selected by s_addr[2] alone)
//   REG0 (s_addr[2]=0): [21:0] SRC, [31:22] LEN (words)
//   REG1 (s_addr[2]=1): write [21:0] DST, [31] START, [30] DONE clear (write-1)
//                       read  [21:0] DST, [31] BUSY, [30] DONE, [29] ERR
//
// Build option: define DMA_IRQ_EN to drive irq from DONE; otherwise irq is tied low.
module dma_copy_engine #(
   parameter int unsigned ADDR_BITS = 22
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        s_req,
   input  logic        s_we,
   input  logic [31:0] s_addr,
   input  logic [31:0] s_wdata,
   output logic        s_gnt,
   output logic        s_rvalid,
   output logic [31:0] s_rdata,
   output logic        m_req,
   output logic        m_we,
   output logic [31:0] m_addr,
   output logic [31:0] m_wdata,
   output logic [3:0]  m_be,
   input  logic        m_gnt,
   input  logic        m_rvalid,
   input  logic [31:0] m_rdata,
   output logic        irq
);

   typedef enum logic [2:0] {StIdle, StRdReq, StRdWait, StWrReq, StWrWait} state_e;

   localparam logic [ADDR_BITS-1:0] AddrStep = ADDR_BITS'(4);

   state_e               state_q, state_d;
   logic [21:0]          src_q, src_d, dst_q, dst_d;
   logic [9:0]           len_q, len_d, cnt_q, cnt_d;
   logic                 done_q, done_d, err_q, err_d;
   logic [ADDR_BITS-1:0] cur_src_q, cur_src_d, cur_dst_q, cur_dst_d;
   logic                 m_req_q, m_req_d, m_we_q, m_we_d;
   logic [31:0]          m_addr_q, m_addr_d, m_wdata_q, m_wdata_d;
   logic                 s_rvalid_q, s_rvalid_d;
   logic [31:0]          s_rdata_q, s_rdata_d;
   logic                 busy, wr_reg0, wr_reg1;
   logic [31:0]          reg0_val, reg1_val;
   logic                 unused_s_addr;

   // Word-aligned, zero-extended bus address from a working pointer.
   function automatic logic [31:0] word_addr(input logic [ADDR_BITS-1:0] a);
      logic [ADDR_BITS-1:0] w;
      w = a;
      w[1:0] = 2'b00;
      return 32'(w);
   endfunction

   assign busy     = (state_q != StIdle);
   assign wr_reg0  = s_req & s_we & ~s_addr[2];
   assign wr_reg1  = s_req & s_we & s_addr[2];
   assign reg0_val = {len_q, src_q};
   assign reg1_val = {busy, done_q, err_q, 7'b0, dst_q};
   assign unused_s_addr = ^{s_addr[31:3], s_addr[1:0]};

   always_comb begin
      state_d    = state_q;
      src_d      = src_q;
      dst_d      = dst_q;
      len_d      = len_q;
      cnt_d      = cnt_q;
      done_d     = done_q;
      err_d      = err_q;
      cur_src_d  = cur_src_q;
      cur_dst_d  = cur_dst_q;
      m_req_d    = m_req_q;
      m_we_d     = m_we_q;
      m_addr_d   = m_addr_q;
      m_wdata_d  = m_wdata_q;
      s_rvalid_d = s_req & ~s_we;
      s_rdata_d  = s_rdata_q;

      if (s_req && !s_we) begin
         s_rdata_d = s_addr[2] ? reg1_val : reg0_val;
      end

      // Address fields are frozen while a copy runs; DONE-clear always applies,
      // and is evaluated before START so a combined write clears then starts.
      if (wr_reg0 && !busy) begin
         src_d = s_wdata[21:0];
         len_d = s_wdata[31:22];
      end
      if (wr_reg1) begin
         if (s_wdata[30]) done_d = 1'b0;
         if (busy) begin
            if (s_wdata[31]) err_d = 1'b1;
         end else begin
            dst_d = s_wdata[21:0];
         end
      end

      unique case (state_q)
         StIdle: begin
            if (wr_reg1 && s_wdata[31]) begin
               if (len_q == 10'd0) begin
                  done_d = 1'b1;
               end else begin
                  state_d   = StRdReq;
                  cnt_d     = len_q;
                  cur_src_d = src_q[ADDR_BITS-1:0];
                  cur_dst_d = s_wdata[ADDR_BITS-1:0];
                  m_req_d   = 1'b1;
                  m_we_d    = 1'b0;
                  m_addr_d  = word_addr(src_q[ADDR_BITS-1:0]);
               end
            end
         end
         StRdReq: begin
            if (m_gnt) begin
               state_d = StRdWait;
               m_req_d = 1'b0;
            end
         end
         StRdWait: begin
            if (m_rvalid) begin
               state_d   = StWrReq;
               m_wdata_d = m_rdata;
               m_we_d    = 1'b1;
               m_addr_d  = word_addr(cur_dst_q);
               m_req_d   = 1'b1;
            end
         end
         StWrReq: begin
            if (m_gnt) begin
               state_d = StWrWait;
               m_req_d = 1'b0;
               m_we_d  = 1'b0;
            end
         end
         StWrWait: begin
            cnt_d     = cnt_q - 10'd1;
            cur_src_d = cur_src_q + AddrStep;
            cur_dst_d = cur_dst_q + AddrStep;
            if (cnt_q != 10'd1) begin
               state_d  = StRdReq;
               m_req_d  = 1'b1;
               m_addr_d = word_addr(cur_src_q + AddrStep);
            end else begin
               state_d = StIdle;
               done_d  = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         src_q      <= '0;
         dst_q      <= '0;
         len_q      <= '0;
         cnt_q      <= '0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         cur_src_q  <= '0;
         cur_dst_q  <= '0;
         m_req_q    <= 1'b0;
         m_we_q     <= 1'b0;
         m_addr_q   <= '0;
         m_wdata_q  <= '0;
         s_rvalid_q <= 1'b0;
         s_rdata_q  <= '0;
      end else begin
         state_q    <= state_d;
         src_q      <= src_d;
         dst_q      <= dst_d;
         len_q      <= len_d;
         cnt_q      <= cnt_d;
         done_q     <= done_d;
         err_q      <= err_d;
         cur_src_q  <= cur_src_d;
         cur_dst_q  <= cur_dst_d;
         m_req_q    <= m_req_d;
         m_we_q     <= m_we_d;
         m_addr_q   <= m_addr_d;
         m_wdata_q  <= m_wdata_d;
         s_rvalid_q <= s_rvalid_d;
         s_rdata_q  <= s_rdata_d;
      end
   end

`ifdef DMA_IRQ_EN
   logic irq_q;
   // Registered from done_d so irq tracks DONE in the same cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) irq_q <= 1'b0;
      else        irq_q <= done_d;
   end
   assign irq = irq_q;
`else
   assign irq = 1'b0;
`endif

   assign s_gnt    = 1'b1;
   assign s_rvalid = s_rvalid_q;
   assign s_rdata  = s_rdata_q;
   assign m_req    = m_req_q;
   assign m_we     = m_we_q;
   assign m_addr   = m_addr_q;
   assign m_wdata  = m_wdata_q;
   assign m_be     = 4'b1111;

endmodule

// File: tb/tb_dma_copy_engine.sv
module tb_dma_copy_engine;

   // REG0 and REG1 both sit inside the decoded window; bit 2 picks the register.
   localparam logic [31:0] Reg0Addr = 32'h000F0F08;
   localparam logic [31:0] Reg1Addr = 32'h000F0F04;

   logic        clk, rst_n;
   logic        s_req, s_we, s_gnt, s_rvalid;
   logic [31:0] s_addr, s_wdata, s_rdata;
   logic        m_req, m_we, m_gnt, m_rvalid;
   logic [31:0] m_addr, m_wdata, m_rdata;
   logic [3:0]  m_be;
   logic        irq;

   int n_checks, n_errors;

   // Environment memory and its observed traffic.
   logic [31:0] mem [logic [31:0]];
   logic [31:0] rd_log[$], wa_log[$], wd_log[$];
   int          stall_cycles, stall_viol, req_count;
   logic [31:0] seed;

   // Reference model state.
   logic [31:0] ref_mem [logic [31:0]];
   logic [31:0] exp_rd[$], exp_wa[$], exp_wd[$];

   dma_copy_engine #(.ADDR_BITS(22)) dut (
      .clk(clk), .rst_n(rst_n),
      .s_req(s_req), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata),
      .s_gnt(s_gnt), .s_rvalid(s_rvalid), .s_rdata(s_rdata),
      .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_be(m_be),
      .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata),
      .irq(irq)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [31:0] init_word(input logic [31:0] a);
      return (a * 32'h9E3779B1) ^ seed;
   endfunction

   // Master-side memory: grants after stall_cycles, read data one full cycle after grant.
   initial begin : mem_model
      int          rd_cnt, st_cnt;
      logic [31:0] rd_addr, h_addr, h_wdata;
      logic        h_we;
      m_gnt = 1'b1; m_rvalid = 1'b0; m_rdata = '0;
      rd_cnt = 0; st_cnt = 0; rd_addr = '0;
      h_addr = '0; h_wdata = '0; h_we = 1'b0;
      forever begin
         @(negedge clk);
         m_rvalid = 1'b0;
         if (!rst_n) begin
            rd_cnt = 0; st_cnt = 0;
         end else if (rd_cnt != 0) begin
            rd_cnt--;
            if (rd_cnt == 0) begin
               m_rvalid = 1'b1;
               m_rdata  = mem.exists(rd_addr) ? mem[rd_addr] : init_word(rd_addr);
            end
         end
         if (m_req) begin
            if (st_cnt > 0 && (m_addr !== h_addr || m_we !== h_we || m_wdata !== h_wdata))
               stall_viol++;
            h_addr = m_addr; h_we = m_we; h_wdata = m_wdata;
            if (st_cnt < stall_cycles) begin
               m_gnt = 1'b0;
               st_cnt++;
            end else begin
               m_gnt = 1'b1;
               st_cnt = 0;
               req_count++;
               if (!m_we) begin
                  rd_cnt  = 2;
                  rd_addr = m_addr;
                  rd_log.push_back(m_addr);
               end else begin
                  mem[m_addr] = m_wdata;
                  wa_log.push_back(m_addr);
                  wd_log.push_back(m_wdata);
               end
            end
         end else begin
            m_gnt  = (stall_cycles == 0);
            st_cnt = 0;
         end
      end
   end

   // Reference copy: word-granular, pointers wrap in the 22-bit space, low bits ignored.
   task automatic ref_copy(input logic [21:0] src, input logic [21:0] dst, input int len);
      logic [21:0] s, d;
      logic [31:0] w;
      exp_rd.delete(); exp_wa.delete(); exp_wd.delete();
      for (int i = 0; i < len; i++) begin
         s = (src & 22'h3FFFFC) + 22'(4 * i);
         d = (dst & 22'h3FFFFC) + 22'(4 * i);
         w = ref_mem.exists({10'd0, s}) ? ref_mem[{10'd0, s}] : init_word({10'd0, s});
         ref_mem[{10'd0, d}] = w;
         exp_rd.push_back({10'd0, s});
         exp_wa.push_back({10'd0, d});
         exp_wd.push_back(w);
      end
   endtask

   function automatic int log_errs();
      int e;
      e = 0;
      if (rd_log.size() != exp_rd.size() || wa_log.size() != exp_wa.size() ||
          wd_log.size() != exp_wd.size()) return 1000;
      foreach (rd_log[i]) if (rd_log[i] !== exp_rd[i]) e++;
      foreach (wa_log[i]) if (wa_log[i] !== exp_wa[i]) e++;
      foreach (wd_log[i]) if (wd_log[i] !== exp_wd[i]) e++;
      return e;
   endfunction

   task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
      s_req = 1'b1; s_we = 1'b1; s_addr = addr; s_wdata = data;
      @(negedge clk);
      s_req = 1'b0; s_we = 1'b0;
   endtask

   task automatic bus_read(input logic [31:0] addr, output logic rv, output logic [31:0] d);
      s_req = 1'b1; s_we = 1'b0; s_addr = addr;
      @(negedge clk);
      s_req = 1'b0;
      rv = s_rvalid;
      d  = s_rdata;
   endtask

   // Programs a copy then polls REG1 every cycle; done_k is the poll index
   // (cycles after the START edge) at which DONE=1 and BUSY=0 is first seen.
   task automatic do_copy(input logic [31:0] reg0, input logic [31:0] reg1, input int stall,
                          input bit inject, output int done_k, output logic [31:0] first_stat,
                          output bit busy_ok);
      logic        rv;
      logic [31:0] d;
      stall_cycles = stall;
      stall_viol = 0;
      rd_log.delete(); wa_log.delete(); wd_log.delete();
      bus_write(Reg0Addr, reg0);
      bus_write(Reg1Addr, reg1);
      done_k = -1; busy_ok = 1'b1; first_stat = '0;
      for (int k = 0; k < 800; k++) begin
         if (inject && k == 3) bus_write(Reg1Addr, 32'h8000_ABCD);
         else if (inject && k == 4) bus_write(Reg0Addr, 32'hFFFF_FFFF);
         else begin
            bus_read(Reg1Addr, rv, d);
            if (k == 0) first_stat = d;
            if (d[30] && !d[31]) begin
               done_k = k;
               break;
            end
            if (!d[31]) busy_ok = 1'b0;
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      n_checks++;
      if ({m_req, m_we, s_rvalid, irq} !== 4'b0) begin
         n_errors++;
         $display("FAIL reset_ctrl: got %b expected 0000", {m_req, m_we, s_rvalid, irq});
      end
      n_checks++;
      if (m_addr !== 32'h0 || m_wdata !== 32'h0 || s_rdata !== 32'h0) begin
         n_errors++;
         $display("FAIL reset_data: got %h %h %h expected zeros", m_addr, m_wdata, s_rdata);
      end
      n_checks++;
      if (s_gnt !== 1'b1 || m_be !== 4'hF) begin
         n_errors++;
         $display("FAIL const_out: got gnt=%b be=%h expected 1 f", s_gnt, m_be);
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_regs();
      logic rv;
      logic [31:0] d;
      bus_write(Reg0Addr, 32'hABC1_2345);
      n_checks++;
      if (s_rvalid !== 1'b0) begin
         n_errors++;
         $display("FAIL write_no_rvalid: got %b expected 0", s_rvalid);
      end
      bus_read(Reg0Addr, rv, d);
      n_checks++;
      if (rv !== 1'b1 || d !== 32'hABC1_2345) begin
         n_errors++;
         $display("FAIL reg0_rb: got rv=%b %h expected 1 abc12345", rv, d);
      end
      @(negedge clk);
      n_checks++;
      if (s_rvalid !== 1'b0) begin
         n_errors++;
         $display("FAIL rvalid_pulse: got %b expected 0", s_rvalid);
      end
      bus_write(Reg1Addr, 32'h0015_5555);
      bus_read(Reg1Addr, rv, d);
      n_checks++;
      if (d !== 32'h0015_5555) begin
         n_errors++;
         $display("FAIL reg1_rb: got %h expected 00155555", d);
      end
   endtask

   task automatic test_basic();
      int k; logic [31:0] st; bit bok;
      ref_copy(22'h0, 22'h100, 4);
      do_copy({10'd4, 22'h0}, 32'h8000_0100, 0, 1'b0, k, st, bok);
      n_checks++;
      if (k !== 20) begin
         n_errors++;
         $display("FAIL basic_done_cycle: got %0d expected 20", k);
      end
      n_checks++;
      if (log_errs() !== 0 || !bok) begin
         n_errors++;
         $display("FAIL basic_copy: got errs=%0d busy_ok=%0b expected 0 1", log_errs(), bok);
      end
   endtask

   task automatic test_stall();
      int k; logic [31:0] st; bit bok;
      ref_copy(22'h40, 22'h140, 4);
      do_copy({10'd4, 22'h40}, 32'h8000_0140, 3, 1'b0, k, st, bok);
      n_checks++;
      if (k !== 44 || !bok) begin
         n_errors++;
         $display("FAIL stall_done: got k=%0d busy_ok=%0b expected 44 1", k, bok);
      end
      n_checks++;
      if (stall_viol !== 0) begin
         n_errors++;
         $display("FAIL stall_stable: got %0d changes expected 0", stall_viol);
      end
      n_checks++;
      if (log_errs() !== 0) begin
         n_errors++;
         $display("FAIL stall_copy: got errs=%0d expected 0", log_errs());
      end
   endtask

   task automatic test_len_zero();
      int k, rc; logic [31:0] st; bit bok; logic rv; logic [31:0] d;
      bus_write(Reg1Addr, 32'h4000_0000);
      bus_read(Reg1Addr, rv, d);
      n_checks++;
      if (d[30] !== 1'b0) begin
         n_errors++;
         $display("FAIL done_clear: got %b expected 0", d[30]);
      end
      rc = req_count;
      do_copy({10'd0, 22'h40}, 32'h8000_0200, 0, 1'b0, k, st, bok);
      repeat (10) @(negedge clk);
      n_checks++;
      if (k !== 0 || st[31:30] !== 2'b01) begin
         n_errors++;
         $display("FAIL len0_done: got k=%0d busy/done=%b expected 0 01", k, st[31:30]);
      end
      n_checks++;
      if (req_count !== rc) begin
         n_errors++;
         $display("FAIL len0_traffic: got %0d requests expected 0", req_count - rc);
      end
   endtask

   task automatic test_busy_start();
      int k; logic [31:0] st; bit bok; logic rv; logic [31:0] d;
      ref_copy(22'h2000, 22'h3000, 8);
      do_copy({10'd8, 22'h2000}, 32'hC000_3000, 0, 1'b1, k, st, bok);
      n_checks++;
      if (k !== 40 || log_errs() !== 0) begin
         n_errors++;
         $display("FAIL busy_start_copy: got k=%0d errs=%0d expected 40 0", k, log_errs());
      end
      bus_read(Reg1Addr, rv, d);
      n_checks++;
      if (d !== 32'h6000_3000) begin
         n_errors++;
         $display("FAIL busy_start_reg1: got %h expected 60003000", d);
      end
      bus_read(Reg0Addr, rv, d);
      n_checks++;
      if (d !== 32'h0200_2000) begin
         n_errors++;
         $display("FAIL busy_start_reg0: got %h expected 02002000", d);
      end
   endtask

   task automatic test_wrap();
      int k; logic [31:0] st; bit bok;
      ref_copy(22'h3FFFFC, 22'h1000, 2);
      do_copy({10'd2, 22'h3FFFFC}, 32'hC000_1000, 0, 1'b0, k, st, bok);
      n_checks++;
      if (rd_log.size() != 2 || log_errs() !== 0 || k !== 10) begin
         n_errors++;
         $display("FAIL wrap: got reads=%0d errs=%0d k=%0d expected 2 0 10",
                  rd_log.size(), log_errs(), k);
      end
   endtask

   task automatic test_random();
      int k, len, stall; logic [31:0] st; bit bok; logic [21:0] src, dst;
      for (int it = 0; it < 6; it++) begin
         src   = 22'h10000 + 22'($urandom_range(0, 32'hFFFF));
         dst   = 22'h20000 + 22'($urandom_range(0, 32'hFFFF));
         len   = $urandom_range(1, 6);
         stall = $urandom_range(0, 2);
         ref_copy(src, dst, len);
         do_copy({10'(len), src}, {2'b11, 8'd0, dst}, stall, 1'b0, k, st, bok);
         n_checks++;
         if (k !== len * (5 + 2 * stall) || !bok || st[31:30] !== 2'b10) begin
            n_errors++;
            $display("FAIL rand%0d_timing: got k=%0d busy_ok=%0b st=%b expected %0d 1 10",
                     it, k, bok, st[31:30], len * (5 + 2 * stall));
         end
         n_checks++;
         if (log_errs() !== 0 || stall_viol !== 0) begin
            n_errors++;
            $display("FAIL rand%0d_copy: got errs=%0d viol=%0d expected 0 0",
                     it, log_errs(), stall_viol);
         end
      end
   endtask

   task automatic test_irq();
      logic exp_set;
`ifdef DMA_IRQ_EN
      exp_set = 1'b1;
`else
      exp_set = 1'b0;
`endif
      n_checks++;
      if (irq !== exp_set) begin
         n_errors++;
         $display("FAIL irq_set: got %b expected %b", irq, exp_set);
      end
      bus_write(Reg1Addr, 32'h4000_0000);
      n_checks++;
      if (irq !== 1'b0) begin
         n_errors++;
         $display("FAIL irq_clear: got %b expected 0", irq);
      end
   endtask

   task automatic test_reset_mid();
      int hits; logic rv; logic [31:0] d;
      stall_cycles = 3;
      bus_write(Reg0Addr, {10'd8, 22'h5000});
      bus_write(Reg1Addr, 32'h8003_0000);
      hits = 0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (m_req && m_we) begin
            hits = 1;
            break;
         end
      end
      n_checks++;
      if (hits !== 1) begin
         n_errors++;
         $display("FAIL mid_reach_wr: got %0d expected 1", hits);
      end
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (m_req !== 1'b0) begin
         n_errors++;
         $display("FAIL mid_async_req: got %b expected 0", m_req);
      end
      @(negedge clk);
      n_checks++;
      if ({m_we, irq, s_rvalid} !== 3'b0 || m_addr !== 32'h0 || m_wdata !== 32'h0) begin
         n_errors++;
         $display("FAIL mid_reset_out: got %b %h %h expected zeros", {m_we, irq, s_rvalid},
                  m_addr, m_wdata);
      end
      rst_n = 1'b1;
      hits = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (m_req) hits++;
      end
      n_checks++;
      if (hits !== 0) begin
         n_errors++;
         $display("FAIL mid_no_retry: got %0d req cycles expected 0", hits);
      end
      bus_read(Reg1Addr, rv, d);
      n_checks++;
      if (d !== 32'h0) begin
         n_errors++;
         $display("FAIL mid_reg1: got %h expected 0", d);
      end
      bus_read(Reg0Addr, rv, d);
      n_checks++;
      if (d !== 32'h0) begin
         n_errors++;
         $display("FAIL mid_reg0: got %h expected 0", d);
      end
   endtask

   initial begin
      n_checks = 0; n_errors = 0;
      stall_cycles = 0; stall_viol = 0; req_count = 0;
      seed = $urandom;
      rst_n = 1'b0;
      s_req = 1'b0; s_we = 1'b0; s_addr = '0; s_wdata = '0;
      @(negedge clk);
      test_reset();
      test_regs();
      test_basic();
      test_stall();
      test_len_zero();
      test_busy_start();
      test_wrap();
      test_random();
      test_irq();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
